// File: rtl/hpc_stack_seq_pkg.sv
// Shared types for the PC sequencer: the op-code enum built from the shared
// op-code header, plus a helper to size the stack occupancy count.
`ifndef HPC_OPS_SVH
`include "hpc_ops.sv"
`endif

package hpc_stack_seq_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = `HPC_OP_HOLD,
        OP_INC  = `HPC_OP_INC,
        OP_LOAD = `HPC_OP_LOAD,
        OP_REL  = `HPC_OP_REL,
        OP_CALL = `HPC_OP_CALL,
        OP_RET  = `HPC_OP_RET
    } hpc_op_e;

    // Occupancy needs one extra bit so that "completely full" is representable.
    function automatic int depth_width(input int entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/hpc_ops.sv
// Op-code constants shared by the instruction decoder and the PC sequencer.
// Guarded so it can be compiled standalone or pulled into other sources.
`ifndef HPC_OPS_SVH
`define HPC_OPS_SVH

`define HPC_OP_HOLD 3'd0
`define HPC_OP_INC  3'd1
`define HPC_OP_LOAD 3'd2
`define HPC_OP_REL  3'd3
`define HPC_OP_CALL 3'd4
`define HPC_OP_RET  3'd5

`endif

// File: rtl/hpc_ret_stack.sv
// Return-address stack: register array plus occupancy pointer, with
// registered full/empty flags that move on the same edge as depth.
module hpc_ret_stack
    import hpc_stack_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                push_data,
    output logic [WIDTH-1:0]                top,
    output logic [depth_width(DEPTH)-1:0]   depth,
    output logic                            full,
    output logic                            empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = depth_width(DEPTH);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    depth_reg, depth_next;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    top_ptr;

    // Low bits of depth index the next free slot; minus one (wrapping) is the top.
    assign wr_ptr  = depth_reg[AW-1:0];
    assign top_ptr = depth_reg[AW-1:0] - AW'(1);

    always_comb begin
        depth_next = depth_reg;
        if (push && !full_reg) begin
            depth_next = depth_reg + DW'(1);
        end else if (pop && !empty_reg) begin
            depth_next = depth_reg - DW'(1);
        end
        full_next  = (depth_next == DEPTH_MAX);
        empty_next = (depth_next == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            depth_reg <= depth_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
        end
    end

    // Storage is deliberately not reset; only entries below depth are meaningful.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (push && !full_reg && (wr_ptr == AW'(gi))) begin
                mem[gi] <= push_data;
            end
        end
    end

    assign top   = mem[top_ptr];
    assign depth = depth_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/hpc_stack_seq.sv
// Program-counter sequencer with relative branches, stall, and a hardware
// return-address stack with sticky overflow/underflow fault flags.
`ifndef HPC_OPS_SVH
`include "hpc_ops.sv"
`endif

module hpc_stack_seq
    import hpc_stack_seq_pkg::*;
#(
    parameter int              WIDTH        = 16,
    parameter int              DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            en,
    input  logic [2:0]                      op,
    input  logic [WIDTH-1:0]                in,
    input  logic                            err_clear,
    output logic [WIDTH-1:0]                out,
    output logic [depth_width(DEPTH)-1:0]   depth,
    output logic                            full,
    output logic                            empty,
    output logic                            err_ovf,
    output logic                            err_unf
);

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             err_ovf_reg, err_ovf_next;
    logic             err_unf_reg, err_unf_next;
    logic             push, pop;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] pc_plus_one;
    logic             stk_full, stk_empty;

    assign pc_plus_one = pc_reg + WIDTH'(1);

    hpc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus_one),
        .top       (ret_addr),
        .depth     (depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pc_next      = pc_reg;
        err_ovf_next = err_ovf_reg;
        err_unf_next = err_unf_reg;
        push         = 1'b0;
        pop          = 1'b0;
        if (en) begin
            // Clear first so a fault raised by this same op overrides it.
            if (err_clear) begin
                err_ovf_next = 1'b0;
                err_unf_next = 1'b0;
            end
            case (hpc_op_e'(op))
                OP_INC:  pc_next = pc_plus_one;
                OP_LOAD: pc_next = in;
                OP_REL:  pc_next = pc_reg + in;
                OP_CALL: begin
                    if (stk_full) begin
                        err_ovf_next = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_next = in;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        err_unf_next = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_next = ret_addr;
                    end
                end
                default: pc_next = pc_reg;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg      <= RESET_VECTOR;
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            err_ovf_reg <= err_ovf_next;
            err_unf_reg <= err_unf_next;
        end
    end

    assign out     = pc_reg;
    assign full    = stk_full;
    assign empty   = stk_empty;
    assign err_ovf = err_ovf_reg;
    assign err_unf = err_unf_reg;

endmodule

// File: doc/hpc_stack_seq.md
# hpc_stack_seq

Parametrised program-counter sequencer; successor to the 16-bit load/increment PC. Adds configurable width, PC-relative branching, a stall enable, and a hardware return-address stack for call/return, with full/empty flags and sticky overflow/underflow fault flags. Sits between the instruction decoder (which supplies `op`/`in`) and the instruction memory address port (`out`).

## Interface
- `WIDTH`, 16: PC and address width in bits.
- `DEPTH`, 8: return-stack entries; power of two, at least 2.
- `RESET_VECTOR`, 0: PC value applied on reset; WIDTH bits.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `en`  in  1: advance enable; 0 = stall, all state held.
- `op`  in  3: operation code; encodings below.
- `in`  in  WIDTH: absolute target for LOAD/CALL; two's-complement offset for REL.
- `err_clear`  in  1: clears both fault flags.
- `out`  out  WIDTH: current PC, registered.
- `depth`  out  $clog2(DEPTH)+1: number of valid stack entries.
- `full`  out  1: `depth == DEPTH`.
- `empty`  out  1: `depth == 0`.
- `err_ovf`  out  1: sticky; a CALL was issued while full.
- `err_unf`  out  1: sticky; a RET was issued while empty.

## Operation
- Op encodings: HOLD=0, INC=1, LOAD=2, REL=3, CALL=4, RET=5. Codes 6 and 7 behave as HOLD.
- Priority: `reset` > `en==0` (everything held, including `err_clear`) > `err_clear`/`op`.
- INC: `out <= out + 1`.
- LOAD: `out <= in`.
- REL: `out <= out + in`, computed modulo 2^WIDTH, so a negative offset moves backwards.
- CALL, not full:
  - push `out + 1` (mod 2^WIDTH) onto the stack;
  - `out <= in`; `depth` increments.
- CALL, full: the stack is unchanged and `out` holds; `err_ovf <= 1`.
- RET, not empty:
  - `out <=` top entry;
  - pop, so `depth` decrements.
- RET, empty: `out` holds; `err_unf <= 1`.
- `err_clear` and a faulting op in the same cycle: the fault wins, so the flag stays 1.
- All arithmetic wraps. INC at all-ones gives 0; REL overflow is truncated to WIDTH bits.
- Stack storage is not reset. An entry is readable only while `depth` covers it.

## Timing
- Every output is registered and updates on the rising edge that samples the op. One cycle of latency from `op` to `out`; no combinational path from inputs to outputs.
- `full`, `empty`, and the error flags change on the same edge as `depth`.
- Reset values:
  - `out = RESET_VECTOR`;
  - `depth = 0`;
  - `full = 0`, `empty = 1`;
  - `err_ovf = 0`, `err_unf = 0`.
- Reset asserted mid-sequence (for example between a CALL and its RET): state clears asynchronously, and prior stack contents are lost.
- Back-to-back CALL and RET on consecutive enabled cycles are fully supported, with no bubbles.

## Structure
- Shared include header with a `define` guard holds the op-code constants (`HPC_OP_HOLD` through `HPC_OP_RET`). The decoder and this block both include it.
- One sub-module, `hpc_ret_stack`:
  - parameters WIDTH and DEPTH;
  - ports push, pop, push data, top, depth, full, empty;
  - holds the register array and the stack pointer.
- The top level owns the PC register, next-PC multiplexing, and the fault flags.

## Test plan
- Reset, INC×3, then INC from 0xFFFF (WIDTH=16) → `out` goes 0, 1, 2, 3, then wraps 0xFFFF → 0x0000. `empty=1` throughout.
- LOAD 0x0100, REL 0xFFFC, REL 0x0010 → `out` = 0x0100, 0x00FC, 0x010C.
- At 0x0010: CALL 0x0200, CALL 0x0300, RET, RET →
  - `out` = 0x0200, 0x0300, 0x0201, 0x0011;
  - `depth` = 1, 2, 1, 0.
- Fill to DEPTH=8, then CALL 0x0500 → `full=1`, `out` unchanged, `err_ovf=1`. Then `err_clear` → `err_ovf=0` and `depth` stays 8.
- RET while empty at 0x0042 → `out` stays 0x0042 and `err_unf=1`. The flag persists through following INCs until `err_clear`.
- `en=0` with CALL 0x0700 → no state change. Assert `reset` between clock edges after two CALLs → `out=RESET_VECTOR` and `depth=0` before the next edge.
